// File: rtl/id_regread_pkg.sv
// id_regread_pkg: shared widths, counts and types for the decode-stage register read block
package id_regread_pkg;
    localparam int REG_W = 16;
    localparam int NREGS = 8;
    localparam int SEL_W = 3;
    localparam int PEND_W = 2;
    localparam logic [PEND_W-1:0] DRAIN_INIT = 2'd3;
    typedef logic [REG_W-1:0] data_t;
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/id_regread_if.sv
// id_regread_if: decode/issue/writeback bundle; master drives requests, slave returns operands, stall and err
interface id_regread_if;
    import id_regread_pkg::*;
    sel_t rd_sel1, rd_sel2, issue_wr_sel, wb_wr_sel;
    logic rd_en1, rd_en2, issue_valid, issue_wr_en, wb_wr_en, flush;
    data_t wb_data, rd_data1, rd_data2;
    logic stall, err;
    modport master (
        output rd_sel1, rd_sel2, rd_en1, rd_en2, issue_valid, issue_wr_en, issue_wr_sel,
        output wb_wr_en, wb_wr_sel, wb_data, flush,
        input rd_data1, rd_data2, stall, err
    );
    modport slave (
        input rd_sel1, rd_sel2, rd_en1, rd_en2, issue_valid, issue_wr_en, issue_wr_sel,
        input wb_wr_en, wb_wr_sel, wb_data, flush,
        output rd_data1, rd_data2, stall, err
    );
endinterface

// File: rtl/id_regread_rf_scoreboard.sv
// rf_scoreboard: per-register pending-writer counters, post-flush drain window, stall and err generation
module rf_scoreboard
    import id_regread_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  sel_t rd_sel1,
    input  sel_t rd_sel2,
    input  logic rd_en1,
    input  logic rd_en2,
    input  logic issue_valid,
    input  logic issue_wr_en,
    input  sel_t issue_wr_sel,
    input  logic wb_wr_en,
    input  sel_t wb_wr_sel,
    input  logic flush,
    output logic stall,
    output logic err
);
    pend_t pend [NREGS];
    pend_t pend_nxt [NREGS];
    pend_t drain;
    logic haz1, haz2, sat, accept, wb_zero;
    logic inc [NREGS];
    logic dec [NREGS];
    always_comb begin
        haz1 = rd_en1 && pend[rd_sel1] != '0 && !(pend[rd_sel1] == 2'd1 && wb_wr_en && wb_wr_sel == rd_sel1);
        haz2 = rd_en2 && pend[rd_sel2] != '0 && !(pend[rd_sel2] == 2'd1 && wb_wr_en && wb_wr_sel == rd_sel2);
        sat = issue_wr_en && pend[issue_wr_sel] == '1 && !(wb_wr_en && wb_wr_sel == issue_wr_sel);
        stall = issue_valid && (haz1 || haz2 || sat);
        accept = issue_valid && !stall && !flush;
        wb_zero = wb_wr_en && pend[wb_wr_sel] == '0;
        for (int r = 0; r < NREGS; r++) begin
            inc[r] = accept && issue_wr_en && issue_wr_sel == sel_t'(r);
            dec[r] = wb_wr_en && wb_wr_sel == sel_t'(r) && pend[r] != '0;
            pend_nxt[r] = flush ? '0 :
                          (inc[r] && !dec[r]) ? pend[r] + 1'b1 :
                          (dec[r] && !inc[r]) ? pend[r] - 1'b1 : pend[r];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) pend[r] <= '0;
            drain <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend[r] <= pend_nxt[r];
            drain <= flush ? DRAIN_INIT : (drain != '0 ? drain - 1'b1 : drain);
            err <= wb_zero && drain == '0 && !flush;
        end
    end
endmodule

// File: rtl/id_regread.sv
// id_regread: 8x16 register file with write-before-read bypass and scoreboard stall (clk, rst, bus: id_regread_if.slave)
module id_regread
    import id_regread_pkg::*;
(
    input logic clk,
    input logic rst,
    id_regread_if.slave bus
);
    data_t regs [NREGS];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (bus.wb_wr_en) begin
            regs[bus.wb_wr_sel] <= bus.wb_data;
        end
    end
    always_comb begin
        bus.rd_data1 = (bus.wb_wr_en && bus.wb_wr_sel == bus.rd_sel1) ? bus.wb_data : regs[bus.rd_sel1];
        bus.rd_data2 = (bus.wb_wr_en && bus.wb_wr_sel == bus.rd_sel2) ? bus.wb_data : regs[bus.rd_sel2];
    end
    rf_scoreboard u_sb (
        .clk(clk),
        .rst(rst),
        .rd_sel1(bus.rd_sel1),
        .rd_sel2(bus.rd_sel2),
        .rd_en1(bus.rd_en1),
        .rd_en2(bus.rd_en2),
        .issue_valid(bus.issue_valid),
        .issue_wr_en(bus.issue_wr_en),
        .issue_wr_sel(bus.issue_wr_sel),
        .wb_wr_en(bus.wb_wr_en),
        .wb_wr_sel(bus.wb_wr_sel),
        .flush(bus.flush),
        .stall(bus.stall),
        .err(bus.err)
    );
endmodule

// File: tb/tb_id_regread.sv
// tb_id_regread: table-driven per-cycle vectors plus a flush-reload sequence for id_regread
module tb_id_regread;
    import id_regread_pkg::*;
    typedef struct {
        logic rst, flush, iv, iwe;
        sel_t isel;
        logic en1;
        sel_t sel1;
        logic en2;
        sel_t sel2;
        logic wbe;
        sel_t wsel;
        data_t wdata;
        logic stall;
        data_t d1, d2;
        logic err;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int bad = 0;
    vec_t tbl[$];
    id_regread_if bus();
    id_regread dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic vec_t v(input logic r, fl, iv, iwe, input int isel, input logic en1, input int sel1,
                               input logic en2, input int sel2, input logic wbe, input int wsel, input data_t wdata,
                               input logic stall, input data_t d1, d2, input logic err);
        vec_t x;
        x.rst = r; x.flush = fl; x.iv = iv; x.iwe = iwe; x.isel = sel_t'(isel);
        x.en1 = en1; x.sel1 = sel_t'(sel1); x.en2 = en2; x.sel2 = sel_t'(sel2);
        x.wbe = wbe; x.wsel = sel_t'(wsel); x.wdata = wdata;
        x.stall = stall; x.d1 = d1; x.d2 = d2; x.err = err;
        return x;
    endfunction
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic apply(input vec_t x, input string tag);
        rst = x.rst;
        bus.flush = x.flush; bus.issue_valid = x.iv; bus.issue_wr_en = x.iwe; bus.issue_wr_sel = x.isel;
        bus.rd_en1 = x.en1; bus.rd_sel1 = x.sel1; bus.rd_en2 = x.en2; bus.rd_sel2 = x.sel2;
        bus.wb_wr_en = x.wbe; bus.wb_wr_sel = x.wsel; bus.wb_data = x.wdata;
        #1;
        check({tag, "_stall"}, 16'(bus.stall), 16'(x.stall));
        check({tag, "_rd_data1"}, bus.rd_data1, x.d1);
        check({tag, "_rd_data2"}, bus.rd_data2, x.d2);
        check({tag, "_err"}, 16'(bus.err), 16'(x.err));
        @(posedge clk);
        @(negedge clk);
    endtask
    initial begin
        rst = 1'b1;
        bus.flush = 0; bus.issue_valid = 0; bus.issue_wr_en = 0; bus.issue_wr_sel = '0;
        bus.rd_en1 = 0; bus.rd_sel1 = '0; bus.rd_en2 = 0; bus.rd_sel2 = '0;
        bus.wb_wr_en = 0; bus.wb_wr_sel = '0; bus.wb_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tbl.push_back(v(0,0,0,0,0, 0,3,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,1,3, 0,3,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,3,0,0, 1,3,16'h1234, 0,16'h1234,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,3,0,0, 0,0,16'h0000, 0,16'h1234,16'h0000,0));
        tbl.push_back(v(0,0,1,1,5, 0,3,0,0, 0,0,16'h0000, 0,16'h1234,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,5,1,3, 0,0,16'h0000, 1,16'h0000,16'h1234,0));
        tbl.push_back(v(0,0,1,0,0, 1,5,0,0, 1,5,16'hBEEF, 0,16'hBEEF,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,5,0,0, 0,0,16'h0000, 0,16'hBEEF,16'h0000,0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0,0,1,1,2, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,1,2, 0,0,0,0, 0,0,16'h0000, 1,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,1,2, 0,2,0,0, 1,2,16'h0222, 0,16'h0222,16'h0000,0));
        tbl.push_back(v(0,0,1,1,2, 0,2,0,0, 0,0,16'h0000, 1,16'h0222,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,2,0,0, 1,2,16'h0333, 1,16'h0333,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 0,0,1,2, 0,0,16'h0000, 1,16'h0000,16'h0333,0));
        tbl.push_back(v(0,0,0,0,0, 0,6,0,0, 1,6,16'h6666, 0,16'h6666,16'h0000,0));
        tbl.push_back(v(0,0,0,0,0, 0,6,0,0, 0,0,16'h0000, 0,16'h6666,16'h0000,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0,0,1,1,1, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,1,1,1,7, 0,1,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,7,1,1, 1,1,16'h0101, 0,16'h0000,16'h0101,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0,0, 0,0,16'h0000, 0,16'h0101,16'h0000,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0,0, 1,1,16'h0102, 0,16'h0102,16'h0000,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0,0, 1,1,16'h0103, 0,16'h0103,16'h0000,0));
        tbl.push_back(v(0,0,0,0,0, 0,1,0,0, 0,0,16'h0000, 0,16'h0103,16'h0000,1));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,1,4, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,1,4, 0,4,0,0, 1,4,16'h4444, 0,16'h4444,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,4,0,0, 0,0,16'h0000, 1,16'h4444,16'h0000,0));
        tbl.push_back(v(1,0,1,1,4, 0,4,0,0, 1,4,16'h5555, 0,16'h5555,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,4,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        tbl.push_back(v(0,0,1,0,0, 1,3,1,2, 0,0,16'h0000, 0,16'h0000,16'h0000,0));
        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
        apply(v(0,1,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_flush_a");
        apply(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_idle1");
        apply(v(0,1,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_flush_b");
        apply(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_idle2");
        apply(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_idle3");
        apply(v(0,0,0,0,0, 0,5,0,0, 1,5,16'h0055, 0,16'h0055,16'h0000,0), "reload_wb_drain1");
        apply(v(0,0,0,0,0, 0,5,0,0, 1,5,16'h0056, 0,16'h0056,16'h0000,0), "reload_wb_drain0");
        apply(v(0,0,0,0,0, 0,5,0,0, 0,0,16'h0000, 0,16'h0056,16'h0000,1), "reload_err_pulse");
        apply(v(0,0,0,0,0, 0,0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,0), "reload_err_clear");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
